// File: rtl/obi_mem_bridge_pkg.sv
// rtl/obi_mem_bridge_pkg.sv - shared constants and types for the OBI memory bridge
// Purpose: default MMIO addresses, stall LFSR seed/taps, response-select enum and the
//          LFSR step function shared by the bridge and its stall generator.
package obi_mem_bridge_pkg;

  localparam logic [31:0] PRINT_ADDR_DEF = 32'h1000_0000;
  localparam logic [31:0] EXIT_ADDR_DEF  = 32'h2000_0000;
  localparam logic [31:0] CYCLE_ADDR_DEF = 32'h1500_0000;
  localparam logic [15:0] LFSR_SEED_DEF  = 16'hACE1;

  // Taps 16,14,13,11 of a right-shifting Fibonacci register map to bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Source of data_rdata_o during the response cycle.
  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_CYCLE,
    SEL_ZERO
  } resp_sel_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {^(state & LFSR_TAPS), state[15:1]};
  endfunction

endpackage

// File: rtl/mem_stall_lfsr.sv
// rtl/mem_stall_lfsr.sv - pseudo-random grant stall generator
// Purpose: 16-bit Fibonacci LFSR that advances every cycle; requests a stall whenever
//          its two low bits are zero and stalling is enabled.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (LFSR returns to SEED)
//   en_i     stall enable
//   stall_o  1 = withhold grant this cycle
module mem_stall_lfsr
  import obi_mem_bridge_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic stall_o
);

  logic [15:0] lfsr_q;

  // Free-running regardless of en_i, so the stall pattern depends only on the seed
  // and the number of cycles since reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign stall_o = en_i & (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/obi_mem_bridge.sv
// rtl/obi_mem_bridge.sv - OBI data port to dual-port RAM port B bridge with MMIO window
// Purpose: accepts one OBI transaction per cycle, forwards RAM hits to the RAM port,
//          services console print / exit / cycle-counter registers, flags unmapped
//          accesses and returns a response exactly one cycle after each grant.
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   data_req_i/gnt_o/addr_i/we_i/     OBI request channel
//   be_i/wdata_i
//   data_rvalid_o, data_rdata_o       OBI response channel (latency 1)
//   ram_en_o/addr_o/we_o/be_o/        RAM port B request (same cycle as grant)
//   wdata_o, ram_rdata_i              RAM read data (one cycle after access)
//   print_valid_o, print_char_o       console byte strobe and byte
//   exit_valid_o, exit_value_o        sticky exit flag and code
//   err_o                             one-cycle pulse after an unmapped access
module obi_mem_bridge
  import obi_mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 22,
  parameter logic [31:0] PRINT_ADDR = PRINT_ADDR_DEF,
  parameter logic [31:0] EXIT_ADDR  = EXIT_ADDR_DEF,
  parameter logic [31:0] CYCLE_ADDR = CYCLE_ADDR_DEF,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic                  print_valid_o,
  output logic [7:0]            print_char_o,
  output logic                  exit_valid_o,
  output logic [31:0]           exit_value_o,
  output logic                  err_o
);

  logic stall;
  logic accept;
  logic ram_hit;
  logic is_print;
  logic is_exit;
  logic is_cycle;
  logic unmapped;
  logic print_hit;
  logic exit_hit;
  resp_sel_e sel_d;

  logic        rvalid_q;
  resp_sel_e   resp_sel_q;
  logic [31:0] cycle_cnt_q;
  logic [31:0] cycle_rdata_q;
  logic        print_valid_q;
  logic [7:0]  print_char_q;
  logic        exit_valid_q;
  logic [31:0] exit_value_q;
  logic        err_q;

  mem_stall_lfsr #(
    .SEED (LFSR_SEED)
  ) u_stall_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (STALL_EN),
    .stall_o (stall)
  );

  assign data_gnt_o = data_req_i & ~stall;
  assign accept     = data_req_i & data_gnt_o;

  // RAM window is everything below 2**ADDR_WIDTH.
  assign ram_hit  = (data_addr_i >> ADDR_WIDTH) == 32'd0;
  assign is_print = data_addr_i == PRINT_ADDR;
  assign is_exit  = data_addr_i == EXIT_ADDR;
  assign is_cycle = data_addr_i == CYCLE_ADDR;
  assign unmapped = ~(ram_hit | is_print | is_exit | is_cycle);

  assign print_hit = accept & is_print & data_we_i & data_be_i[0];
  assign exit_hit  = accept & is_exit & data_we_i;

  // RAM request is presented in the grant cycle; unaligned addresses pass through.
  assign ram_en_o    = accept & ram_hit;
  assign ram_we_o    = accept & ram_hit & data_we_i;
  assign ram_addr_o  = data_addr_i[ADDR_WIDTH-1:0];
  assign ram_be_o    = data_be_i;
  assign ram_wdata_o = data_wdata_i;

  // Only RAM reads and cycle-counter reads return non-zero data.
  always_comb begin
    sel_d = SEL_ZERO;
    if (!data_we_i) begin
      if (ram_hit) begin
        sel_d = SEL_RAM;
      end else if (is_cycle) begin
        sel_d = SEL_CYCLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q      <= 1'b0;
      resp_sel_q    <= SEL_ZERO;
      cycle_cnt_q   <= 32'd0;
      cycle_rdata_q <= 32'd0;
      print_valid_q <= 1'b0;
      print_char_q  <= 8'd0;
      exit_valid_q  <= 1'b0;
      exit_value_q  <= 32'd0;
      err_q         <= 1'b0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_q + 32'd1;
      rvalid_q      <= accept;
      err_q         <= accept & unmapped;
      print_valid_q <= print_hit;
      if (accept) begin
        resp_sel_q <= sel_d;
      end
      // Counter value of the grant cycle, held for the response cycle.
      if (accept && is_cycle && !data_we_i) begin
        cycle_rdata_q <= cycle_cnt_q;
      end
      if (print_hit) begin
        print_char_q <= data_wdata_i[7:0];
      end
      // First exit write wins; the code is frozen until reset.
      if (exit_hit && !exit_valid_q) begin
        exit_valid_q <= 1'b1;
        exit_value_q <= data_wdata_i;
      end
    end
  end

  // RAM data arrives one cycle after the access, i.e. in the response cycle itself.
  always_comb begin
    data_rdata_o = 32'd0;
    if (rvalid_q) begin
      case (resp_sel_q)
        SEL_RAM:   data_rdata_o = ram_rdata_i;
        SEL_CYCLE: data_rdata_o = cycle_rdata_q;
        default:   data_rdata_o = 32'd0;
      endcase
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign print_valid_o = print_valid_q;
  assign print_char_o  = print_char_q;
  assign exit_valid_o  = exit_valid_q;
  assign exit_value_o  = exit_value_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_obi_mem_bridge.sv
// tb/tb_obi_mem_bridge.sv - self-checking bench for obi_mem_bridge
module tb_obi_mem_bridge;
  import obi_mem_bridge_pkg::*;

  localparam int          AW    = 22;
  localparam logic [31:0] P_ADR = 32'h1000_0000;
  localparam logic [31:0] E_ADR = 32'h2000_0000;
  localparam logic [31:0] C_ADR = 32'h1500_0000;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // no-stall instance
  logic          req, we, gnt, rvalid, ram_en, ram_we, print_valid, exit_valid, err;
  logic [31:0]   addr, wdata, rdata, ram_wdata, ram_rdata, exit_value;
  logic [3:0]    be, ram_be;
  logic [AW-1:0] ram_addr;
  logic [7:0]    print_char;

  // stall instance
  logic          req2, gnt2, rvalid2, s_ram_en, s_ram_we, s_print_valid, s_exit_valid, s_err;
  logic [31:0]   s_rdata, s_ram_wdata, s_exit_value;
  logic [3:0]    s_ram_be;
  logic [AW-1:0] s_ram_addr;
  logic [7:0]    s_print_char;

  obi_mem_bridge #(.ADDR_WIDTH(AW), .STALL_EN(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req), .data_gnt_o(gnt), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .data_rvalid_o(rvalid), .data_rdata_o(rdata),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .print_valid_o(print_valid), .print_char_o(print_char),
    .exit_valid_o(exit_valid), .exit_value_o(exit_value), .err_o(err)
  );

  obi_mem_bridge #(.ADDR_WIDTH(AW), .STALL_EN(1'b1), .LFSR_SEED(SEED)) u_stall (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req2), .data_gnt_o(gnt2), .data_addr_i(32'h0000_0040), .data_we_i(1'b0),
    .data_be_i(4'hF), .data_wdata_i(32'h0), .data_rvalid_o(rvalid2), .data_rdata_o(s_rdata),
    .ram_en_o(s_ram_en), .ram_addr_o(s_ram_addr), .ram_we_o(s_ram_we), .ram_be_o(s_ram_be),
    .ram_wdata_o(s_ram_wdata), .ram_rdata_i(32'h0),
    .print_valid_o(s_print_valid), .print_char_o(s_print_char),
    .exit_valid_o(s_exit_valid), .exit_value_o(s_exit_value), .err_o(s_err)
  );

  // Untouched RAM words hold a recognisable pattern.
  function automatic logic [31:0] init_pat(input int idx);
    return (idx * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = nw[k*8 +: 8];
    return r;
  endfunction

  // Behavioural RAM on port B: synchronous, read data one cycle after the access.
  logic [31:0] ram_mem [1024];
  bit          ram_wr  [1024];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr[11:2]] <= merge(ram_wr[ram_addr[11:2]] ? ram_mem[ram_addr[11:2]]
                                         : init_pat(int'(ram_addr[11:2])), ram_wdata, ram_be);
        ram_wr[ram_addr[11:2]]  <= 1'b1;
      end else begin
        ram_rdata <= ram_wr[ram_addr[11:2]] ? ram_mem[ram_addr[11:2]]
                     : init_pat(int'(ram_addr[11:2]));
      end
    end
  end

  // Reference: cycles since reset release and the stall LFSR defined by its taps.
  int          n_edges;
  logic [15:0] m_lfsr;
  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11];
    return {fb, s[15:1]};
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edges = 0;
      m_lfsr  = SEED;
    end else begin
      n_edges = n_edges + 1;
      m_lfsr  = ref_lfsr(m_lfsr);
    end
  end

  int checks = 0;
  int failures = 0;

  // Scoreboard state
  logic [31:0] m_mem [1024];
  logic        p_valid, p_err, p_print, m_exit_v, prev_g, g;
  logic [7:0]  p_char;
  logic [31:0] p_rdata, m_exit_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic do_reset();
    req = 0; req2 = 0; we = 0; addr = 0; be = 0; wdata = 0;
    rst_n = 0;
    p_valid = 0; p_err = 0; p_print = 0; p_char = 0; p_rdata = 0;
    m_exit_v = 0; m_exit_val = 0;
    repeat (2) @(negedge clk);
    chk("rst_rvalid", {31'b0, rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_print_valid", {31'b0, print_valid}, 0);
    chk("rst_print_char", {24'b0, print_char}, 0);
    chk("rst_exit_valid", {31'b0, exit_valid}, 0);
    chk("rst_exit_value", exit_value, 0);
    chk("rst_rvalid2", {31'b0, rvalid2}, 0);
    rst_n = 1;
  endtask

  // One cycle: drive request, check last cycle's response and this cycle's RAM request.
  task automatic step(input logic r, input logic [31:0] a, input logic w,
                      input logic [3:0] b, input logic [31:0] d);
    logic hit, is_p, is_e, is_c, acc;
    int   wi;
    @(negedge clk);
    req = r; addr = a; we = w; be = b; wdata = d;
    #1;
    chk("rvalid", {31'b0, rvalid}, {31'b0, p_valid});
    chk(p_valid ? "rdata" : "rdata_idle", rdata, p_valid ? p_rdata : 32'd0);
    chk("err", {31'b0, err}, {31'b0, p_err});
    chk("print_valid", {31'b0, print_valid}, {31'b0, p_print});
    if (p_print) chk("print_char", {24'b0, print_char}, {24'b0, p_char});
    chk("exit_valid", {31'b0, exit_valid}, {31'b0, m_exit_v});
    chk("exit_value", exit_value, m_exit_val);

    hit  = (a >> AW) == 32'd0;
    is_p = a == P_ADR;
    is_e = a == E_ADR;
    is_c = a == C_ADR;
    wi   = int'(a[11:2]);
    acc  = r;
    chk("gnt", {31'b0, gnt}, {31'b0, r});
    chk("ram_en", {31'b0, ram_en}, {31'b0, acc & hit});
    chk("ram_we", {31'b0, ram_we}, {31'b0, acc & hit & w});
    if (acc && hit) begin
      chk("ram_addr", {10'b0, ram_addr}, {10'b0, a[AW-1:0]});
      chk("ram_be", {28'b0, ram_be}, {28'b0, b});
      chk("ram_wdata", ram_wdata, d);
    end

    p_valid = acc;
    p_err   = acc & ~(hit | is_p | is_e | is_c);
    p_print = acc & is_p & w & b[0];
    p_char  = d[7:0];
    p_rdata = 32'd0;
    if (acc && !w && hit) p_rdata = m_mem[wi];
    if (acc && !w && is_c) p_rdata = 32'(n_edges);
    if (acc && w && hit) m_mem[wi] = merge(m_mem[wi], d, b);
    if (acc && w && is_e && !m_exit_v) begin
      m_exit_v   = 1;
      m_exit_val = d;
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) m_mem[i] = init_pat(i);
    do_reset();

    // RAM write then read-back
    step(1, 32'h0000_0100, 1, 4'hF, 32'hCAFE_BABE);
    step(1, 32'h0000_0100, 0, 4'hF, 32'h0);
    idle();
    // Back-to-back reads
    step(1, 32'h0, 0, 4'hF, 32'h0);
    step(1, 32'h4, 0, 4'hF, 32'h0);
    step(1, 32'h8, 0, 4'hF, 32'h0);
    idle();
    // Partial write, unaligned read, window boundaries
    step(1, 32'h0000_0100, 1, 4'h6, 32'h1122_3344);
    step(1, 32'h0000_0102, 0, 4'hF, 32'h0);
    step(1, 32'h003F_FFFC, 0, 4'hF, 32'h0);
    step(1, 32'h0040_0000, 0, 4'hF, 32'h0);
    idle();
    // Console
    step(1, P_ADR, 1, 4'h1, 32'h0000_0041);
    step(1, P_ADR, 1, 4'h2, 32'h0000_0042);
    idle();
    // Unmapped, write to counter, read of print register
    step(1, 32'h3000_0000, 0, 4'hF, 32'h0);
    step(1, C_ADR, 1, 4'hF, 32'h1234);
    step(1, P_ADR, 0, 4'hF, 32'h0);
    idle();
    // Exit: first write sticks
    step(1, E_ADR, 1, 4'hF, 32'd7);
    step(1, E_ADR, 1, 4'hF, 32'd9);
    step(1, 32'h0000_0100, 0, 4'hF, 32'h0);
    idle();
    chk("exit_value_kept", exit_value, 32'd7);
    // Reset during a response cycle drops rvalid and exit at once
    step(1, 32'h0000_0100, 0, 4'hF, 32'h0);
    @(posedge clk);
    #2;
    chk("rvalid_before_rst", {31'b0, rvalid}, 1);
    rst_n = 0;
    #1;
    chk("rvalid_async_rst", {31'b0, rvalid}, 0);
    chk("exit_async_rst", {31'b0, exit_valid}, 0);
    do_reset();

    // Cycle counter read in the 50th cycle after reset
    for (int i = 1; i < 50; i++) idle();
    step(1, C_ADR, 0, 4'hF, 32'h0);
    chk("cycle_at_50", p_rdata, 32'd50);
    idle();

    // Stall instance: grant follows the reference LFSR, rvalid follows grant
    prev_g = 0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      req2 = (i < 64) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      g = req2 & (m_lfsr[1:0] != 2'b00);
      chk("stall_gnt", {31'b0, gnt2}, {31'b0, g});
      chk("stall_rvalid", {31'b0, rvalid2}, {31'b0, prev_g});
      prev_g = g;
    end
    req2 = 0;

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       a = P_ADR;
        1:       a = E_ADR;
        2:       a = C_ADR;
        3:       a = $urandom;
        default: a = 32'($urandom_range(0, 4095));
      endcase
      step(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
